// File: rtl/path_player.sv
// Answer-LIFO playback: pops the solved path (start -> goal) and emits one
// 2-bit move direction per consecutive coordinate pair over valid/ready.
module path_player #(
  parameter int unsigned COORD_W = 4,
  parameter int unsigned CNT_W   = 9
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               run,
  input  logic               stack_empty,
  input  logic [COORD_W-1:0] stack_top_x,
  input  logic [COORD_W-1:0] stack_top_y,
  output logic               stack_pop,
  output logic               move_valid,
  input  logic               move_ready,
  output logic [1:0]         move_dir,
  output logic [COORD_W-1:0] pos_x,
  output logic [COORD_W-1:0] pos_y,
  output logic [CNT_W-1:0]   move_count,
  output logic               busy,
  output logic               done,
  output logic               error
);

  localparam logic [1:0] DIR_UP    = 2'b00;
  localparam logic [1:0] DIR_RIGHT = 2'b01;
  localparam logic [1:0] DIR_DOWN  = 2'b10;
  localparam logic [1:0] DIR_LEFT  = 2'b11;

  localparam logic [COORD_W-1:0] COORD_MAX = {COORD_W{1'b1}};
  localparam logic [COORD_W-1:0] COORD_ONE = COORD_W'(1);
  localparam logic [CNT_W-1:0]   CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0]   CNT_ONE   = CNT_W'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_FETCH,
    S_EMIT,
    S_DONE,
    S_ERR
  } state_t;

  state_t             r_state;
  state_t             w_state_next;
  logic [COORD_W-1:0] r_pos_x;
  logic [COORD_W-1:0] r_pos_y;
  logic [CNT_W-1:0]   r_count;
  logic [1:0]         r_dir;
  logic [1:0]         w_dir;
  logic               r_valid;
  logic               r_busy;
  logic               r_done;
  logic               r_error;

  logic w_pop;
  logic w_load_pos;
  logic w_clr_count;
  logic w_inc_count;
  logic w_set_dir;
  logic w_same_x;
  logic w_same_y;
  logic w_up;
  logic w_right;
  logic w_down;
  logic w_left;
  logic w_step_ok;

  // Unit-step detection without modular wrap: an edge coordinate has no neighbour past it.
  assign w_same_x  = (stack_top_x == r_pos_x);
  assign w_same_y  = (stack_top_y == r_pos_y);
  assign w_right   = w_same_y && (r_pos_x != COORD_MAX) && (stack_top_x == r_pos_x + COORD_ONE);
  assign w_left    = w_same_y && (r_pos_x != '0)        && (stack_top_x == r_pos_x - COORD_ONE);
  assign w_down    = w_same_x && (r_pos_y != COORD_MAX) && (stack_top_y == r_pos_y + COORD_ONE);
  assign w_up      = w_same_x && (r_pos_y != '0)        && (stack_top_y == r_pos_y - COORD_ONE);
  assign w_step_ok = w_up | w_right | w_down | w_left;

  always_comb begin
    w_dir = DIR_UP;
    if (w_right)     w_dir = DIR_RIGHT;
    else if (w_down) w_dir = DIR_DOWN;
    else if (w_left) w_dir = DIR_LEFT;
  end

  // Next-state and datapath strobes
  always_comb begin
    w_state_next = r_state;
    w_pop        = 1'b0;
    w_load_pos   = 1'b0;
    w_clr_count  = 1'b0;
    w_inc_count  = 1'b0;
    w_set_dir    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (run) w_state_next = stack_empty ? S_DONE : S_LOAD;
      end
      S_LOAD: begin
        w_pop        = 1'b1;
        w_load_pos   = 1'b1;
        w_clr_count  = 1'b1;
        w_state_next = S_FETCH;
      end
      S_FETCH: begin
        if (stack_empty) begin
          w_state_next = S_DONE;
        end else if (w_step_ok) begin
          w_set_dir    = 1'b1;
          w_state_next = S_EMIT;
        end else begin
          w_state_next = S_ERR;
        end
      end
      S_EMIT: begin
        if (move_ready) begin
          w_pop        = 1'b1;
          w_load_pos   = 1'b1;
          w_inc_count  = 1'b1;
          w_state_next = S_FETCH;
        end
      end
      S_DONE:  w_state_next = S_IDLE;
      S_ERR:   w_state_next = S_ERR;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Pop is gated in the reset cycle so an abort never consumes an entry.
  assign stack_pop = w_pop & ~rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_pos_x <= '0;
      r_pos_y <= '0;
      r_count <= '0;
      r_dir   <= DIR_UP;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_error <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (w_load_pos) begin
        r_pos_x <= stack_top_x;
        r_pos_y <= stack_top_y;
      end
      if (w_clr_count)                               r_count <= '0;
      else if (w_inc_count && (r_count != CNT_MAX))  r_count <= r_count + CNT_ONE;
      if (w_set_dir) r_dir <= w_dir;
      r_valid <= (w_state_next == S_EMIT);
      r_busy  <= (w_state_next != S_IDLE);
      r_done  <= (w_state_next == S_DONE);
      r_error <= (w_state_next == S_ERR);
    end
  end

  assign move_valid = r_valid;
  assign move_dir   = r_dir;
  assign pos_x      = r_pos_x;
  assign pos_y      = r_pos_y;
  assign move_count = r_count;
  assign busy       = r_busy;
  assign done       = r_done;
  assign error      = r_error;

endmodule

// File: tb/tb_path_player.sv
// Bench for path_player: LIFO model, path-level reference model, directed and random runs.
module tb_path_player;
  localparam int unsigned COORD_W = 4;
  localparam int unsigned CNT_W   = 9;

  logic               clk = 1'b0;
  logic               rst;
  logic               run;
  logic               stack_empty;
  logic [COORD_W-1:0] stack_top_x;
  logic [COORD_W-1:0] stack_top_y;
  logic               stack_pop;
  logic               move_valid;
  logic               move_ready;
  logic [1:0]         move_dir;
  logic [COORD_W-1:0] pos_x;
  logic [COORD_W-1:0] pos_y;
  logic [CNT_W-1:0]   move_count;
  logic               busy;
  logic               done;
  logic               error;

  int n_pass = 0;
  int n_tot  = 0;

  always #5 clk = ~clk;

  path_player #(.COORD_W(COORD_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .run(run), .stack_empty(stack_empty),
    .stack_top_x(stack_top_x), .stack_top_y(stack_top_y), .stack_pop(stack_pop),
    .move_valid(move_valid), .move_ready(move_ready), .move_dir(move_dir),
    .pos_x(pos_x), .pos_y(pos_y), .move_count(move_count),
    .busy(busy), .done(done), .error(error)
  );

  // Load requests from the stimulus side; the LIFO model copies them on the next edge.
  int ld_x[$];
  int ld_y[$];
  int ld_seq = 0;

  // First-word-fall-through LIFO model: pops on the edge, shows post-pop state next cycle.
  int lifo_x[$];
  int lifo_y[$];
  int last_seq = 0;
  int pops = 0;
  always @(posedge clk) begin
    if (stack_pop) begin
      pops++;
      if (lifo_x.size() > 0) begin
        void'(lifo_x.pop_front());
        void'(lifo_y.pop_front());
      end
    end
    if (ld_seq != last_seq) begin
      last_seq = ld_seq;
      lifo_x = ld_x;
      lifo_y = ld_y;
    end
    stack_empty <= (lifo_x.size() == 0);
    stack_top_x <= (lifo_x.size() > 0) ? COORD_W'(lifo_x[0]) : '0;
    stack_top_y <= (lifo_y.size() > 0) ? COORD_W'(lifo_y[0]) : '0;
  end

  // Output monitor, sampled mid-cycle.
  int       cyc = 0;
  int       got_dir[$];
  int       got_cyc[$];
  int       done_cnt = 0;
  int       done_cyc = 0;
  int       busy_cnt = 0;
  int       stall_bad = 0;
  logic     prev_stall = 1'b0;
  logic [1:0] prev_dir = 2'b00;
  always @(negedge clk) begin
    cyc++;
    if (move_valid && move_ready) begin
      got_dir.push_back(int'(move_dir));
      got_cyc.push_back(cyc);
    end
    if (prev_stall && move_valid && (move_dir !== prev_dir)) stall_bad++;
    prev_stall = move_valid && !move_ready;
    prev_dir   = move_dir;
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (busy) busy_cnt++;
  end

  // Reference model state (what the player should show after a run)
  int exp_dirs[$];
  int m_px = 0;
  int m_py = 0;
  int m_cnt = 0;
  int run_t0 = 0;
  int run_g0 = 0;

  task automatic lifo_load(input int xs[$], input int ys[$]);
    ld_x = xs;
    ld_y = ys;
    ld_seq++;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    run = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    m_px = 0; m_py = 0; m_cnt = 0;
  endtask

  // Walks the loaded path with signed arithmetic; stops at the first non-unit step.
  task automatic model(output bit e_err, output int e_pops);
    int dx;
    int dy;
    exp_dirs.delete();
    e_err  = 1'b0;
    e_pops = 0;
    if (ld_x.size() == 0) return;
    m_px = ld_x[0]; m_py = ld_y[0]; m_cnt = 0; e_pops = 1;
    for (int i = 1; i < ld_x.size(); i++) begin
      dx = ld_x[i] - m_px;
      dy = ld_y[i] - m_py;
      if (dx == 0 && dy == -1)      exp_dirs.push_back(0);
      else if (dx == 1 && dy == 0)  exp_dirs.push_back(1);
      else if (dx == 0 && dy == 1)  exp_dirs.push_back(2);
      else if (dx == -1 && dy == 0) exp_dirs.push_back(3);
      else begin
        e_err = 1'b1;
        break;
      end
      m_px = ld_x[i]; m_py = ld_y[i]; m_cnt++; e_pops++;
    end
  endtask

  // mode 0: ready always high; 1: ready low for the first 5 cycles of each offer; 2: random ready
  task automatic play(input int mode, output bit timed_out);
    int k;
    int d0;
    k = 0;
    d0 = done_cnt;
    @(posedge clk); #1;
    run = 1'b1;
    move_ready = (mode == 0);
    run_t0 = cyc + 1;
    @(posedge clk); #1;
    run = 1'b0;
    timed_out = 1'b1;
    for (int i = 0; i < 600; i++) begin
      if (mode == 1) begin
        if (move_valid) k++; else k = 0;
        move_ready = (k > 5);
      end else if (mode == 2) begin
        move_ready = ($urandom_range(0, 2) != 0);
      end else begin
        move_ready = 1'b1;
      end
      @(posedge clk); #1;
      if (done_cnt != d0 || error === 1'b1) begin
        timed_out = 1'b0;
        break;
      end
    end
    move_ready = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
  endtask

  task automatic check_run(input string name, input int mode);
    bit e_err;
    int e_pops;
    int p0;
    int p1;
    int d0;
    int s0;
    bit to;
    int n;
    model(e_err, e_pops);
    p0 = pops; d0 = done_cnt; s0 = stall_bad; run_g0 = got_dir.size();
    play(mode, to);
    n_tot++; if (to) $display("FAIL %s timeout: no done/error within budget", name); else n_pass++;
    n = got_dir.size() - run_g0;
    n_tot++; if (n != exp_dirs.size()) $display("FAIL %s move_total: got %0d want %0d", name, n, exp_dirs.size()); else n_pass++;
    for (int i = 0; i < n && i < exp_dirs.size(); i++) begin
      n_tot++;
      if (got_dir[run_g0+i] != exp_dirs[i]) $display("FAIL %s dir[%0d]: got %0d want %0d", name, i, got_dir[run_g0+i], exp_dirs[i]);
      else n_pass++;
    end
    n_tot++; if (error !== e_err) $display("FAIL %s error: got %0b want %0b", name, error, e_err); else n_pass++;
    n_tot++; if (done_cnt - d0 != (e_err ? 0 : 1)) $display("FAIL %s done_pulses: got %0d want %0d", name, done_cnt - d0, e_err ? 0 : 1); else n_pass++;
    n_tot++; if (pops - p0 != e_pops) $display("FAIL %s pops: got %0d want %0d", name, pops - p0, e_pops); else n_pass++;
    n_tot++; if (move_count !== CNT_W'(m_cnt)) $display("FAIL %s move_count: got %0d want %0d", name, move_count, m_cnt); else n_pass++;
    n_tot++; if (pos_x !== COORD_W'(m_px) || pos_y !== COORD_W'(m_py))
      $display("FAIL %s pos: got (%0d,%0d) want (%0d,%0d)", name, pos_x, pos_y, m_px, m_py);
    else n_pass++;
    n_tot++; if (stall_bad != s0) $display("FAIL %s dir_stable: %0d changes while stalled, want 0", name, stall_bad - s0); else n_pass++;
    if (e_err) begin
      p1 = pops;
      move_ready = 1'b1;
      repeat (5) begin @(posedge clk); #1; end
      move_ready = 1'b0;
      n_tot++; if (error !== 1'b1 || busy !== 1'b1 || move_valid !== 1'b0)
        $display("FAIL %s err_sticky: error=%0b busy=%0b valid=%0b want 1 1 0", name, error, busy, move_valid);
      else n_pass++;
      n_tot++; if (pops != p1 || done_cnt != d0) $display("FAIL %s err_quiet: extra pops %0d done %0d want 0 0", name, pops - p1, done_cnt - d0); else n_pass++;
      do_reset();
      n_tot++; if (error !== 1'b0 || busy !== 1'b0) $display("FAIL %s err_cleared: error=%0b busy=%0b want 0 0", name, error, busy); else n_pass++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; run = 1'b0; move_ready = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    n_tot++; if ({stack_pop, move_valid, busy, done, error} !== 5'b0)
      $display("FAIL reset_flags: pop/valid/busy/done/err=%b want 00000", {stack_pop, move_valid, busy, done, error});
    else n_pass++;
    n_tot++; if (move_dir !== 2'b00 || move_count !== '0 || pos_x !== '0 || pos_y !== '0)
      $display("FAIL reset_regs: dir=%0d count=%0d pos=(%0d,%0d) want all 0", move_dir, move_count, pos_x, pos_y);
    else n_pass++;
    rst = 1'b0;
  endtask

  task automatic test_empty();
    int b0;
    lifo_load('{}, '{});
    b0 = busy_cnt;
    check_run("empty", 0);
    n_tot++; if (done_cyc - run_t0 != 1) $display("FAIL empty_done_cycle: got c%0d want c1", done_cyc - run_t0); else n_pass++;
    n_tot++; if (busy_cnt - b0 != 1) $display("FAIL empty_busy_cycles: got %0d want 1", busy_cnt - b0); else n_pass++;
  endtask

  task automatic test_basic();
    lifo_load('{0, 1, 1, 2}, '{0, 0, 1, 1});
    check_run("basic", 0);
    for (int i = 0; i < 3 && run_g0 + i < got_cyc.size(); i++) begin
      n_tot++;
      if (got_cyc[run_g0+i] - run_t0 != 3 + 2*i)
        $display("FAIL basic_valid_cycle[%0d]: got c%0d want c%0d", i, got_cyc[run_g0+i] - run_t0, 3 + 2*i);
      else n_pass++;
    end
    n_tot++; if (done_cyc - run_t0 != 9) $display("FAIL basic_done_cycle: got c%0d want c9", done_cyc - run_t0); else n_pass++;
  endtask

  task automatic test_stall();
    lifo_load('{0, 1, 1, 2}, '{0, 0, 1, 1});
    check_run("stall", 1);
  endtask

  task automatic test_error();
    lifo_load('{3, 3, 5}, '{3, 2, 2});
    check_run("nonadjacent", 0);
    lifo_load('{3, 3}, '{3, 3});
    check_run("same_cell", 0);
  endtask

  task automatic test_wrap();
    lifo_load('{15, 0}, '{0, 0});
    check_run("wrap_15_to_0", 0);
    lifo_load('{0, 15}, '{0, 0});
    check_run("wrap_0_to_15", 2);
  endtask

  task automatic test_reset_mid();
    int p0;
    lifo_load('{2, 3}, '{3, 3});
    @(posedge clk); #1;
    run = 1'b1; move_ready = 1'b0;
    @(posedge clk); #1;
    run = 1'b0;
    for (int i = 0; i < 10 && move_valid !== 1'b1; i++) begin @(posedge clk); #1; end
    n_tot++; if (move_valid !== 1'b1) $display("FAIL rst_mid_emit: move_valid=%0b want 1", move_valid); else n_pass++;
    repeat (2) begin @(posedge clk); #1; end
    p0 = pops;
    rst = 1'b1; move_ready = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; move_ready = 1'b0;
    n_tot++; if (pops != p0) $display("FAIL rst_mid_pop: %0d pops in reset cycle want 0", pops - p0); else n_pass++;
    n_tot++; if ({stack_pop, move_valid, busy, done, error} !== 5'b0 || move_dir !== 2'b00 ||
                 move_count !== '0 || pos_x !== '0 || pos_y !== '0)
      $display("FAIL rst_mid_outputs: flags=%b dir=%0d cnt=%0d pos=(%0d,%0d) want all 0",
               {stack_pop, move_valid, busy, done, error}, move_dir, move_count, pos_x, pos_y);
    else n_pass++;
    m_px = 0; m_py = 0; m_cnt = 0;
    lifo_load('{4, 3}, '{4, 4});
    check_run("rst_mid_rerun", 0);
  endtask

  task automatic test_random();
    int xs[$];
    int ys[$];
    int n;
    int x;
    int y;
    int d;
    for (int it = 0; it < 30; it++) begin
      xs.delete(); ys.delete();
      n = $urandom_range(0, 8);
      x = $urandom_range(0, 15);
      y = $urandom_range(0, 15);
      for (int i = 0; i < n; i++) begin
        xs.push_back(x); ys.push_back(y);
        if ($urandom_range(0, 99) < 12) begin
          x = $urandom_range(0, 15);
          y = $urandom_range(0, 15);
        end else begin
          d = $urandom_range(0, 3);
          if (d == 0) y = (y - 1) & 15;
          else if (d == 1) x = (x + 1) & 15;
          else if (d == 2) y = (y + 1) & 15;
          else x = (x - 1) & 15;
        end
      end
      lifo_load(xs, ys);
      check_run($sformatf("random%0d", it), 2);
    end
  endtask

  initial begin
    rst = 1'b1;
    run = 1'b0;
    move_ready = 1'b0;
    test_reset();
    test_empty();
    test_basic();
    test_stall();
    test_error();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
